// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine transaction controller:
// state encoding, coin codes with their yuan values, and price selection.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2
  } state_t;

  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_1    = 3'd1;
  localparam logic [2:0] COIN_5    = 3'd2;
  localparam logic [2:0] COIN_10   = 3'd3;

  function automatic logic coin_valid(input logic [2:0] code);
    return (code == COIN_1) || (code == COIN_5) || (code == COIN_10);
  endfunction

  // Invalid codes map to 0 so the caller only has to test coin_valid().
  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  return 8'd1;
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] price_sel(input logic [1:0] idx,
                                           input logic [7:0] p1,
                                           input logic [7:0] p2,
                                           input logic [7:0] p3);
    case (idx)
      2'd1:    return p1;
      2'd2:    return p2;
      2'd3:    return p3;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_det.sv
// "Went non-zero" detector: flags the cycle in which a level leaves zero.
module edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic         rise
);

  logic [W-1:0] prev;

  // NOTE: prev follows d unconditionally, so during reset it already holds the
  // live input and levels still held at reset release do not count as events.
  always_ff @(posedge clk) begin
    prev <= d;
  end

  assign rise = (d != '0) && (prev == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin/press/cancel events, credit accumulation,
// sale and refund sequencing with fully registered outputs.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE1      = 3,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 8,
  parameter int BAL_MAX     = 99,
  parameter int DISP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] coin,
  input  logic [1:0] about,
  input  logic       press,
  input  logic       cancel,
  output logic [7:0] balance,
  output logic       dispense,
  output logic [1:0] item,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       short
);

  localparam logic [7:0] P1    = 8'(PRICE1);
  localparam logic [7:0] P2    = 8'(PRICE2);
  localparam logic [7:0] P3    = 8'(PRICE3);
  localparam logic [8:0] BMAX  = 9'(BAL_MAX);
  localparam int         CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         change_lat;
  logic               coin_ev, press_ev, cancel_ev;
  logic [8:0]         sum;
  logic [7:0]         price;
  logic               coin_ok;

  edge_det #(.W(3)) u_coin_ed   (.clk(clk), .d(coin),   .rise(coin_ev));
  edge_det #(.W(1)) u_press_ed  (.clk(clk), .d(press),  .rise(press_ev));
  edge_det #(.W(1)) u_cancel_ed (.clk(clk), .d(cancel), .rise(cancel_ev));

  // 9-bit sum so a large credit plus a coin can never wrap past BAL_MAX.
  assign sum     = {1'b0, balance} + {1'b0, coin_value(coin)};
  assign coin_ok = coin_valid(coin) && (sum <= BMAX);
  assign price   = price_sel(about, P1, P2, P3);

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      change_lat   <= '0;
      balance      <= '0;
      dispense     <= 1'b0;
      item         <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      short        <= 1'b0;
    end else begin
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      short        <= 1'b0;

      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (cancel_ev) begin
            coin_reject <= coin_ev;
            if (state == ST_COLLECT) begin
              change       <= balance;
              change_valid <= 1'b1;
              balance      <= '0;
              state        <= ST_IDLE;
            end
          end else if (press_ev) begin
            // A press outranks a coin even when no product is selected.
            coin_reject <= coin_ev;
            if (about != 2'd0) begin
              if (balance >= price) begin
                item       <= about;
                change_lat <= balance - price;
                balance    <= '0;
                dispense   <= 1'b1;
                cnt        <= CNT_W'(DISP_CYCLES - 1);
                state      <= ST_DISPENSE;
              end else begin
                short <= 1'b1;
              end
            end
          end else if (coin_ev) begin
            if (coin_ok) begin
              balance <= sum[7:0];
              state   <= ST_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        ST_DISPENSE: begin
          coin_reject <= coin_ev;
          if (cnt == '0) begin
            dispense     <= 1'b0;
            item         <= '0;
            change       <= change_lat;
            change_valid <= 1'b1;
            change_lat   <= '0;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
